vga_stream_sink: RTL
====================

Name: vga_stream_sink

Overview:
- Terminal consumer of the grayscale filter pipeline's valid/ready pixel stream.
- Buffers pixels in a small FIFO and releases exactly one pixel per visible raster cycle, aligned to the sync generator's hcount/vcount.
- Detects underflow and frame misalignment, then resynchronises on the next start-of-frame marker.
- Sits between the last filter stage and the VGA RGB assignment.

Parameters:
- DATA_W, 8, pixel width.
- DEPTH, 16, FIFO entries; power of two, at least 4.
- H_VISIBLE, 640, visible pixels per line.
- V_VISIBLE, 480, visible lines per frame.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- pix_in  in  DATA_W  upstream pixel.
- valid_in  in  1  upstream pixel valid.
- sof_in  in  1  marks pix_in as pixel (0,0) of a frame; qualified by valid_in.
- module_ready  out  1  sink can accept pix_in this cycle.
- hcount  in  10  raster column.
- vcount  in  10  raster row.
- visible  in  1  raster in active area.
- pix_out  out  DATA_W  pixel to VGA, registered.
- pix_valid_out  out  1  pix_out holds a real pixel.
- underflow  out  1  one-cycle pulse on underflow.
- locked  out  1  high while in STREAM.
- underflow_count  out  16  saturating underflow count; see Optional Feature.

Behaviour:
- **Reset values:** pix_out=0, pix_valid_out=0, underflow=0, locked=0, underflow_count=0, FIFO empty, state=WAIT_SOF, pop counter=0.
- **Handshake:**
  - A transfer occurs when valid_in && module_ready.
  - module_ready=1 in WAIT_SOF, where non-SOF transfers are discarded.
  - In PRIME and STREAM, module_ready = !full, with full derived from the registered count.
  - module_ready=0 in RESYNC.
  - Upstream holds pix_in/valid_in stable until the transfer.
- **Pop/latency:**
  - A pop happens on a cycle with visible=1 in STREAM (and on the lock cycle, see PRIME).
  - pix_out and pix_valid_out update on the next clock edge: 1-cycle latency from visible.
  - The integrator delays hsync/vsync/blank by 1 cycle.
  - When visible=0, pix_valid_out=0 on the next cycle; pix_out holds.
- **FIFO:**
  - A simultaneous push and pop at full is impossible, because module_ready=0.
  - A simultaneous push and pop at mid-level leaves the count unchanged.
  - A push to an empty FIFO is not forwarded in the same cycle; there is no bypass.
  - Pointers wrap modulo DEPTH.
- **State machine:**
  - WAIT_SOF -> PRIME on an accepted transfer with sof_in=1; that pixel is written.
  - PRIME -> STREAM when count >= DEPTH/2 && visible && hcount==0 && vcount==0. That cycle pops; locked rises next cycle. Otherwise stay, accepting pixels.
  - STREAM -> RESYNC on underflow: visible=1 && empty. In that case:
    - pix_valid_out=0 and pix_out=0 next cycle.
    - underflow pulses for 1 cycle.
  - STREAM -> RESYNC on misalignment: an accepted sof_in while the pop counter is not 0 and not H_VISIBLE*V_VISIBLE. The SOF pixel is dropped.
  - RESYNC: flush the FIFO in 1 cycle, clear the pop counter, then go to WAIT_SOF.
- **Pop counter:**
  - 19-bit; increments per pop.
  - Wraps to 0 after H_VISIBLE*V_VISIBLE pops.
  - An SOF accepted while the counter is 0 or equals the frame size is legal.
- **Reset mid-operation:** asynchronous return to reset values; FIFO contents are discarded.
- **Underflow count:** saturates at 16'hFFFF.

Optional Feature:
- Macro: STREAM_SINK_STATS_EN.
- **Defined:** underflow_count increments on each underflow pulse and on each misalignment resync, saturating at 16'hFFFF; cleared only by reset.
- **Undefined:** the underflow_count port is still present and tied to 0; no counter logic is instantiated.

Decomposition:
- Package vga_stream_pkg holds:
  - the sink_state_t enum (WAIT_SOF, PRIME, STREAM, RESYNC);
  - H_VISIBLE_DEF=640, V_VISIBLE_DEF=480, PIX_W=8;
  - FRAME_PIXELS localparam function.
- One sub-module, pix_fifo: synchronous FIFO with parameters DATA_W and DEPTH.
  - Inputs: push, pop, flush.
  - Outputs: dout, full, empty, count.
- The FSM, pop counter and output register stay in vga_stream_sink.

Test Plan:
- **Reset:** reset=0 for 3 cycles while valid_in=1 -> all outputs 0, module_ready=1, locked=0.
- **Pre-SOF discard:** 5 pixels with sof_in=0 and values 1..5 -> discarded; FIFO count stays 0; state WAIT_SOF.
- **Lock and stream:**
  - Stimulus: SOF pixel 8'hA0, then 7 more pixels A1..A7; raster reaches (0,0) visible.
  - Response: pix_out=A0 with pix_valid_out=1 one cycle later, then A1, A2... on consecutive visible cycles; locked=1.
- **Backpressure:**
  - Stimulus: with DEPTH=16, hold visible=0 while pushing 20 pixels.
  - Response: module_ready=0 after 16 are accepted; none lost; order preserved on the next visible run.
- **Underflow:**
  - Stimulus: in STREAM, stop valid_in until the FIFO drains during a visible run.
  - Response: next cycle underflow=1 for 1 cycle, pix_valid_out=0, pix_out=0, locked drops; state passes through RESYNC to WAIT_SOF. underflow_count=1 with STREAM_SINK_STATS_EN, 0 without.
- **Misaligned SOF:** in STREAM, sof_in accepted at pop counter 1000 -> RESYNC, FIFO flushed (count=0), then WAIT_SOF; the next SOF relocks at raster (0,0).

Source files
------------

// File: rtl/vga_stream_pkg.sv
// Shared types and constants for the VGA stream sink and its pixel FIFO.
package vga_stream_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF,
        PRIME,
        STREAM,
        RESYNC
    } sink_state_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int V_VISIBLE_DEF = 480;
    localparam int PIX_W         = 8;

    function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
        return h * v;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO with a one-cycle flush; read data is the head entry, shown combinationally.
module pix_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vga_stream_sink.sv
// Raster-aligned sink for the filter pixel stream: buffers, locks on SOF, detects underflow/misalignment.
// Optional saturating resync counter on underflow_count when STREAM_SINK_STATS_EN is defined.
module vga_stream_sink
    import vga_stream_pkg::*;
#(
    parameter int DATA_W    = PIX_W,
    parameter int DEPTH     = 16,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              valid_in,
    input  logic              sof_in,
    output logic              module_ready,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              visible,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_valid_out,
    output logic              underflow,
    output logic              locked,
    output logic [15:0]       underflow_count
);
    localparam int          CW          = $clog2(DEPTH) + 1;
    localparam int unsigned FRAME_PIX   = frame_pixels(H_VISIBLE, V_VISIBLE);
    localparam logic [18:0] FRAME_CNT   = 19'(FRAME_PIX);
    localparam logic [18:0] FRAME_LAST  = 19'(FRAME_PIX - 1);
    localparam logic [CW-1:0] HALF_FULL = CW'(DEPTH / 2);

    sink_state_t       state_q, state_d;
    logic [18:0]       pop_cnt_q, pop_cnt_d;
    logic [DATA_W-1:0] pix_out_q, pix_out_d;
    logic              pix_valid_q, pix_valid_d;
    logic              underflow_q, underflow_d;
    logic              locked_q, locked_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              xfer, misalign, at_origin;

    pix_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (pix_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        unique case (state_q)
            WAIT_SOF:      module_ready = 1'b1;
            PRIME, STREAM: module_ready = !fifo_full;
            default:       module_ready = 1'b0;
        endcase
    end

    assign xfer      = valid_in && module_ready;
    assign at_origin = visible && (hcount == '0) && (vcount == '0);
    // An SOF is only legal on a frame boundary of the pop count.
    assign misalign  = (state_q == STREAM) && xfer && sof_in &&
                       (pop_cnt_q != '0) && (pop_cnt_q != FRAME_CNT);

    always_comb begin
        state_d     = state_q;
        pop_cnt_d   = pop_cnt_q;
        pix_out_d   = pix_out_q;
        pix_valid_d = 1'b0;
        underflow_d = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        unique case (state_q)
            WAIT_SOF: begin
                if (xfer && sof_in) begin
                    fifo_push = 1'b1;
                    state_d   = PRIME;
                end
            end
            PRIME: begin
                fifo_push = xfer;
                if (at_origin && (fifo_count >= HALF_FULL)) begin
                    fifo_pop    = 1'b1;
                    pix_out_d   = fifo_dout;
                    pix_valid_d = 1'b1;
                    pop_cnt_d   = (pop_cnt_q == FRAME_LAST) ? '0 : pop_cnt_q + 1'b1;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                fifo_push = xfer && !misalign;
                if (visible) begin
                    if (fifo_empty) begin
                        underflow_d = 1'b1;
                        pix_out_d   = '0;
                        state_d     = RESYNC;
                    end else begin
                        fifo_pop    = 1'b1;
                        pix_out_d   = fifo_dout;
                        pix_valid_d = 1'b1;
                        pop_cnt_d   = (pop_cnt_q == FRAME_LAST) ? '0 : pop_cnt_q + 1'b1;
                    end
                end
                if (misalign) state_d = RESYNC;
            end
            default: begin
                fifo_flush = 1'b1;
                pop_cnt_d  = '0;
                state_d    = WAIT_SOF;
            end
        endcase
        locked_d = (state_d == STREAM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_SOF;
            pop_cnt_q   <= '0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pop_cnt_q   <= pop_cnt_d;
            pix_out_q   <= pix_out_d;
            pix_valid_q <= pix_valid_d;
            underflow_q <= underflow_d;
            locked_q    <= locked_d;
        end
    end

    assign pix_out       = pix_out_q;
    assign pix_valid_out = pix_valid_q;
    assign underflow     = underflow_q;
    assign locked        = locked_q;

`ifdef STREAM_SINK_STATS_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;
    logic        resync_evt;

    // Underflow and misalignment both leave STREAM for RESYNC; count each exit once.
    assign resync_evt = (state_q == STREAM) && (state_d == RESYNC);
    assign uf_cnt_d   = (resync_evt && (uf_cnt_q != 16'hFFFF)) ? uf_cnt_q + 16'd1 : uf_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) uf_cnt_q <= '0;
        else        uf_cnt_q <= uf_cnt_d;
    end

    assign underflow_count = uf_cnt_q;
`else
    assign underflow_count = '0;
`endif

endmodule
